// File: rtl/dmem_responder.sv
// Big-endian word memory with byte/half lane select; one request in flight, response LATENCY cycles after accept.
// Backpressure: req_ready drops while a request is counting down; a new request may be accepted in the response cycle.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:31] addr_to_mem,
  input  logic        write_enable_to_mem,
  input  logic        byte_to_mem,
  input  logic        half_word_to_mem,
  input  logic        sign_extend_to_mem,
  input  logic [0:31] data_to_mem,
  output logic [0:31] data_from_mem,
  output logic        resp_valid,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                  state, state_n;
  logic [3:0]              cnt, cnt_n;
  logic                    rst_sync;
  logic                    accept, access;

  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [1:0]              r_off;
  logic                    r_we, r_byte, r_half, r_sext;
  logic [0:31]             r_data;

  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [1:0]              acc_off;
  logic                    acc_we, acc_byte, acc_half, acc_sext, acc_mis;
  logic [0:31]             acc_data;

  logic [0:31]             mem [0:2**ADDR_WIDTH-1];
  logic [0:31]             rd_word, load_val, wr_word;
  logic [0:7]              lane_b;
  logic [0:15]             lane_h;
  logic [0:3]              byte_en;
  logic                    mis_q;
  logic                    unused_addr;

  assign unused_addr = ^addr_to_mem[0:29-ADDR_WIDTH];

  // Single flop: first edge after release arms, second edge may accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= 1'b0;
    else        rst_sync <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE, RESP: begin
        state_n = IDLE;
        if (req_valid && rst_sync) begin
          accept = 1'b1;
          cnt_n  = LAT_M1;
          if (LAT_M1 == 4'd0) begin
            state_n = RESP;
            access  = 1'b1;
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - 4'd1;
        if (cnt_n == 4'd0) begin
          state_n = RESP;
          access  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_ready  = (state != BUSY);
  assign resp_valid = (state == RESP);
  assign misaligned = resp_valid & mis_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx  <= '0;
      r_off  <= 2'd0;
      r_we   <= 1'b0;
      r_byte <= 1'b0;
      r_half <= 1'b0;
      r_sext <= 1'b0;
      r_data <= '0;
    end else if (accept) begin
      r_idx  <= addr_to_mem[30-ADDR_WIDTH:29];
      r_off  <= addr_to_mem[30:31];
      r_we   <= write_enable_to_mem;
      r_byte <= byte_to_mem;
      r_half <= half_word_to_mem;
      r_sext <= sign_extend_to_mem;
      r_data <= data_to_mem;
    end
  end

  // With LATENCY=1 the access happens on the accepting edge, so use the live request.
  always_comb begin
    if (state == BUSY) begin
      acc_idx  = r_idx;
      acc_off  = r_off;
      acc_we   = r_we;
      acc_byte = r_byte;
      acc_half = r_half;
      acc_sext = r_sext;
      acc_data = r_data;
    end else begin
      acc_idx  = addr_to_mem[30-ADDR_WIDTH:29];
      acc_off  = addr_to_mem[30:31];
      acc_we   = write_enable_to_mem;
      acc_byte = byte_to_mem;
      acc_half = half_word_to_mem;
      acc_sext = sign_extend_to_mem;
      acc_data = data_to_mem;
    end
  end

  always_comb begin
    rd_word = mem[acc_idx];
    case (acc_off)
      2'd0:    lane_b = rd_word[0:7];
      2'd1:    lane_b = rd_word[8:15];
      2'd2:    lane_b = rd_word[16:23];
      default: lane_b = rd_word[24:31];
    endcase
    lane_h = acc_off[1] ? rd_word[16:31] : rd_word[0:15];
    if (acc_byte) begin
      acc_mis  = 1'b0;
      load_val = {{24{acc_sext & lane_b[0]}}, lane_b};
      wr_word  = {4{acc_data[24:31]}};
      byte_en  = 4'b0000;
      byte_en[acc_off] = 1'b1;
    end else if (acc_half) begin
      acc_mis  = acc_off[0];
      load_val = {{16{acc_sext & lane_h[0]}}, lane_h};
      wr_word  = {2{acc_data[16:31]}};
      byte_en  = acc_off[1] ? 4'b0011 : 4'b1100;
    end else begin
      acc_mis  = (acc_off != 2'd0);
      load_val = rd_word;
      wr_word  = acc_data;
      byte_en  = 4'b1111;
    end
  end

  always_ff @(posedge clock) begin
    if (access && acc_we && !acc_mis) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[acc_idx][8*k +: 8] <= wr_word[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_from_mem <= '0;
      mis_q         <= 1'b0;
    end else if (access) begin
      mis_q <= acc_mis;
      if (acc_mis)     data_from_mem <= '0;
      else if (!acc_we) data_from_mem <= load_val;
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined processor's DMEM port. It accepts one load or store request at a time, holds word-organised big-endian storage, and applies byte and half-word lane selection with sign or zero extension. It returns results after a programmable latency using a valid/ready handshake, so a pipeline stall can be derived from `req_ready` and `resp_valid`. It sits between the processor's MEM-stage outputs and the memory model in system benches.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits of storage (2^ADDR_WIDTH words).
- `LATENCY`, default 2: cycles from request acceptance to `resp_valid`. Legal range is 1..15.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0).
- `req_valid` input 1: request present this cycle.
- `req_ready` output 1: responder can accept a request this cycle.
- `addr_to_mem` input [0:31]: byte address. Bit 0 is the MSB and bit 31 is the LSB.
- `write_enable_to_mem` input 1: 1 = store, 0 = load.
- `byte_to_mem` input 1: byte access.
- `half_word_to_mem` input 1: half-word access. Ignored when `byte_to_mem`=1.
- `sign_extend_to_mem` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `data_to_mem` input [0:31]: store data, right-justified for sub-word stores.
- `data_from_mem` output [0:31]: load result, held until the next load response.
- `resp_valid` output 1: one-cycle pulse marking completion of the accepted request.
- `misaligned` output 1: qualifies `resp_valid`; the request was misaligned and was not performed.

## Operation
- Storage: 2^ADDR_WIDTH 32-bit words, indexed by `addr[30-ADDR_WIDTH:29]`.
  - Higher address bits are ignored, so addresses alias and wrap.
  - Storage is not reset.
- Byte lanes are big-endian. Offset k = `addr[30:31]` selects word bits [8k:8k+7].
- Half-word offset 0 selects bits [0:15]; offset 2 selects bits [16:31].
- Alignment rules:
  - Word access requires `addr[30:31]`=00.
  - Half-word access requires `addr[31]`=0.
  - Byte access is always aligned.
- Loads:
  - The selected lane is placed in [24:31] for a byte, or [16:31] for a half-word.
  - Upper bits are filled with the lane MSB when `sign_extend_to_mem`=1, otherwise with 0.
  - A word load returns the word unchanged; the sign-extend input is ignored.
- Stores:
  - Byte store writes `data_to_mem[24:31]` into lane k.
  - Half-word store writes `data_to_mem[16:31]` into the selected half.
  - Word store writes all 32 bits.
  - Unselected lanes are preserved (byte write enables, no read-modify-write race).
- Misaligned request: no storage write and `data_from_mem` is set to 0. `resp_valid` and `misaligned` are both 1 in the response cycle.
- All request fields are latched at acceptance. Input changes after acceptance have no effect.
- FSM states and transitions:
  - IDLE: `req_ready`=1. When `req_valid`=1, latch the request, load counter = LATENCY-1. Go to RESP if the counter is 0, otherwise go to BUSY.
  - BUSY: `req_ready`=0, counter decrements each cycle, `req_valid` is ignored. When the counter is 0 at a rising edge, go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle and `req_ready`=1. A request accepted here goes to BUSY or RESP by the same rule as IDLE; otherwise go to IDLE.
- The access (storage write, or registering `data_from_mem`) is performed on the edge that enters RESP.
- Store responses leave `data_from_mem` unchanged.

## Timing
- Acceptance: a rising edge with `req_valid` & `req_ready`.
- Latency: `resp_valid` is high in the cycle exactly LATENCY cycles after the accepting edge's cycle.
- Throughput: one request per LATENCY cycles, achieved by back-to-back acceptance in RESP.
- Reset values while `reset`=0:
  - state IDLE, counter 0
  - `req_ready`=1
  - `resp_valid`=0, `misaligned`=0
  - `data_from_mem`=0
- Reset mid-operation: the pending request is dropped, a pending store is never committed, and no response is produced.
- Reset release: synchronised internally. The first acceptance can occur on the second rising edge after release.
- `byte_to_mem` and `half_word_to_mem` both 1: treated as a byte access.

## Test plan
- Word round trip, LATENCY=2.
  - Store 0xDEADBEEF at 0x10, then load word 0x10.
  - Each `resp_valid` appears 2 cycles after acceptance; the load returns 0xDEADBEEF with `misaligned`=0.
- Byte loads after the above:
  - signed 0x10 → 0xFFFFFFDE
  - unsigned 0x10 → 0x000000DE
  - signed 0x13 → 0xFFFFFFEF
  - unsigned 0x12 → 0x000000BE
- Half-word store and loads:
  - Store half 0x1234 at 0x12, then load word 0x10 → 0xDEAD1234.
  - Signed half load at 0x10 → 0xFFFFDEAD.
  - Byte store 0x7F at 0x11 followed by word load → 0xDE7F1234.
- Misaligned requests:
  - Word load at 0x11 → `misaligned`=1, `data_from_mem`=0.
  - Half store at 0x13 → `misaligned`=1, and word 0x10 is unchanged.
- Handshake, LATENCY=3 with `req_valid` held high for two loads:
  - Accepts occur in cycles 0 and 3; responses in cycles 3 and 6.
  - `req_ready`=0 in cycles 1-2.
  - With LATENCY=1, responses occur every cycle.
- Reset during BUSY of a store of 0x0 to 0x20, where word 0x20 previously held 0xCAFEF00D:
  - `resp_valid` never asserts.
  - After release, a word load of 0x20 returns 0xCAFEF00D.
